gfx_cmd_sink: RTL and testbench

GFX_CMD_SINK -- requirements
Module: gfx_cmd_sink

---
 rtl/gfx_cmd_sink.sv | 186 ++++++++++++++++++
 tb/tb_gfx_cmd_sink.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_cmd_sink.sv
// Graphics command sink: processor-written sprite table with vsync-driven shadow copy,
// background register and a font RAM with a hardware clear sweep.
module gfx_cmd_sink #(
    parameter int unsigned NSPR    = 32,
    parameter int unsigned FONT_AW = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         sprite_x,
    input  logic [8:0]         sprite_y,
    input  logic [4:0]         sprite_sel,
    input  logic               sprite_pos,
    input  logic               sprite_attr,
    input  logic               sprite_vis,
    input  logic               bck_ch_active,
    input  logic [1:0]         bck,
    input  logic               font_ch_active,
    input  logic               font_en,
    input  logic [FONT_AW-1:0] font_addr,
    input  logic [3:0]         font_data,
    input  logic               font_clr,
    input  logic               vsync,
    input  logic [4:0]         rd_spr,
    output logic [9:0]         rd_x,
    output logic [8:0]         rd_y,
    output logic               rd_vis,
    input  logic [FONT_AW-1:0] rd_font_addr,
    output logic [3:0]         rd_font_data,
    output logic [1:0]         bck_out,
    output logic               font_busy,
    output logic               copy_busy,
    output logic               font_wr_dropped
);

    typedef enum logic {FontIdle, FontClear} font_state_e;
    typedef enum logic {CopyIdle, CopyRun} copy_state_e;

    localparam logic [4:0] LastSpr = 5'(NSPR - 1);

    logic [9:0] act_x_q   [NSPR];
    logic [8:0] act_y_q   [NSPR];
    logic       act_vis_q [NSPR];
    logic [9:0] sh_x_q    [NSPR];
    logic [8:0] sh_y_q    [NSPR];
    logic       sh_vis_q  [NSPR];

    logic [3:0] font_mem [2**FONT_AW];

    font_state_e        font_state_q, font_state_d;
    logic [FONT_AW-1:0] font_ctr_q, font_ctr_d;
    copy_state_e        copy_state_q, copy_state_d;
    logic [4:0]         copy_ctr_q, copy_ctr_d;

    logic       proc_font_wr;
    logic [9:0] rd_x_d;
    logic [8:0] rd_y_d;
    logic       rd_vis_d;

    assign proc_font_wr = font_ch_active & font_en;
    assign font_busy    = (font_state_q == FontClear);
    assign copy_busy    = (copy_state_q == CopyRun);

    always_comb begin
        font_state_d = font_state_q;
        font_ctr_d   = font_ctr_q;
        if (font_clr) begin
            font_state_d = FontClear;
            font_ctr_d   = '0;
        end else if (font_state_q == FontClear) begin
            font_ctr_d = font_ctr_q + 1'b1;
            if (font_ctr_q == '1) begin
                font_state_d = FontIdle;
            end
        end
    end

    always_comb begin
        copy_state_d = copy_state_q;
        copy_ctr_d   = copy_ctr_q;
        if (vsync) begin
            copy_state_d = CopyRun;
            copy_ctr_d   = '0;
        end else if (copy_state_q == CopyRun) begin
            if (copy_ctr_q == LastSpr) begin
                copy_state_d = CopyIdle;
                copy_ctr_d   = '0;
            end else begin
                copy_ctr_d = copy_ctr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            font_state_q    <= FontIdle;
            font_ctr_q      <= '0;
            copy_state_q    <= CopyIdle;
            copy_ctr_q      <= '0;
            bck_out         <= '0;
            font_wr_dropped <= 1'b0;
        end else begin
            font_state_q <= font_state_d;
            font_ctr_q   <= font_ctr_d;
            copy_state_q <= copy_state_d;
            copy_ctr_q   <= copy_ctr_d;
            if (bck_ch_active) begin
                bck_out <= bck;
            end
            if (font_busy && proc_font_wr) begin
                font_wr_dropped <= 1'b1;
            end
        end
    end

    // Decoded per-entry writes; selects >= NSPR match no entry and are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSPR; i++) begin
                act_x_q[i]   <= '0;
                act_y_q[i]   <= '0;
                act_vis_q[i] <= 1'b0;
                sh_x_q[i]    <= '0;
                sh_y_q[i]    <= '0;
                sh_vis_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (sprite_pos && sprite_sel == 5'(i)) begin
                    act_x_q[i] <= sprite_x;
                    act_y_q[i] <= sprite_y;
                end
                if (sprite_attr && sprite_sel == 5'(i)) begin
                    act_vis_q[i] <= sprite_vis;
                end
                if (copy_busy && copy_ctr_q == 5'(i)) begin
                    sh_x_q[i]   <= act_x_q[i];
                    sh_y_q[i]   <= act_y_q[i];
                    sh_vis_q[i] <= act_vis_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_x_d   = '0;
        rd_y_d   = '0;
        rd_vis_d = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            if (rd_spr == 5'(i)) begin
                rd_x_d   = sh_x_q[i];
                rd_y_d   = sh_y_q[i];
                rd_vis_d = sh_vis_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_x   <= '0;
            rd_y   <= '0;
            rd_vis <= 1'b0;
        end else begin
            rd_x   <= rd_x_d;
            rd_y   <= rd_y_d;
            rd_vis <= rd_vis_d;
        end
    end

    // RAM array carries no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (font_busy) begin
            font_mem[font_ctr_q] <= 4'h0;
        end else if (proc_font_wr) begin
            font_mem[font_addr] <= font_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_font_data <= '0;
        end else begin
            rd_font_data <= font_mem[rd_font_addr];
        end
    end

endmodule

// File: tb/tb_gfx_cmd_sink.sv
// Self-checking bench for gfx_cmd_sink: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the command sink.
module tb_gfx_cmd_sink;

    localparam int NS = 32;
    localparam int NF = 2048;

    logic        clk;
    logic        reset;
    logic [9:0]  sprite_x;
    logic [8:0]  sprite_y;
    logic [4:0]  sprite_sel;
    logic        sprite_pos, sprite_attr, sprite_vis;
    logic        bck_ch_active;
    logic [1:0]  bck;
    logic        font_ch_active, font_en;
    logic [10:0] font_addr;
    logic [3:0]  font_data;
    logic        font_clr, vsync;
    logic [4:0]  rd_spr;
    logic [9:0]  rd_x;
    logic [8:0]  rd_y;
    logic        rd_vis;
    logic [10:0] rd_font_addr;
    logic [3:0]  rd_font_data;
    logic [1:0]  bck_out;
    logic        font_busy, copy_busy, font_wr_dropped;

    logic [9:0]  rd_x16;
    logic [8:0]  rd_y16;
    logic        rd_vis16;
    logic [3:0]  rd_font_data16;
    logic [1:0]  bck_out16;
    logic        font_busy16, copy_busy16, font_wr_dropped16;

    gfx_cmd_sink u_dut (
        .clk(clk), .reset(reset),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_sel(sprite_sel),
        .sprite_pos(sprite_pos), .sprite_attr(sprite_attr), .sprite_vis(sprite_vis),
        .bck_ch_active(bck_ch_active), .bck(bck),
        .font_ch_active(font_ch_active), .font_en(font_en), .font_addr(font_addr),
        .font_data(font_data), .font_clr(font_clr), .vsync(vsync),
        .rd_spr(rd_spr), .rd_x(rd_x), .rd_y(rd_y), .rd_vis(rd_vis),
        .rd_font_addr(rd_font_addr), .rd_font_data(rd_font_data),
        .bck_out(bck_out), .font_busy(font_busy), .copy_busy(copy_busy),
        .font_wr_dropped(font_wr_dropped)
    );

    gfx_cmd_sink #(.NSPR(16), .FONT_AW(11)) u_dut16 (
        .clk(clk), .reset(reset),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_sel(sprite_sel),
        .sprite_pos(sprite_pos), .sprite_attr(sprite_attr), .sprite_vis(sprite_vis),
        .bck_ch_active(bck_ch_active), .bck(bck),
        .font_ch_active(font_ch_active), .font_en(font_en), .font_addr(font_addr),
        .font_data(font_data), .font_clr(font_clr), .vsync(vsync),
        .rd_spr(rd_spr), .rd_x(rd_x16), .rd_y(rd_y16), .rd_vis(rd_vis16),
        .rd_font_addr(rd_font_addr), .rd_font_data(rd_font_data16),
        .bck_out(bck_out16), .font_busy(font_busy16), .copy_busy(copy_busy16),
        .font_wr_dropped(font_wr_dropped16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_ax [NS], m_ay [NS], m_av [NS];
    int m_sx [NS], m_sy [NS], m_sv [NS];
    int m_font [NF];
    bit m_fknown [NF];
    int m_bck, m_rdx, m_rdy, m_rdv, m_rdf;
    bit m_rdf_known;
    bit m_fbusy;
    int m_fidx;
    int m_cidx;   // copy index, -1 when no copy in flight
    bit m_dropped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_ax[i] = 0; m_ay[i] = 0; m_av[i] = 0;
            m_sx[i] = 0; m_sy[i] = 0; m_sv[i] = 0;
        end
        for (int i = 0; i < NF; i++) m_fknown[i] = 1'b0;
        m_bck = 0; m_rdx = 0; m_rdy = 0; m_rdv = 0; m_rdf = 0; m_rdf_known = 1'b1;
        m_fbusy = 1'b0; m_fidx = 0; m_cidx = -1; m_dropped = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit wr;
        wr = font_ch_active && font_en;
        m_rdx = m_sx[rd_spr]; m_rdy = m_sy[rd_spr]; m_rdv = m_sv[rd_spr];
        m_rdf = m_font[rd_font_addr]; m_rdf_known = m_fknown[rd_font_addr];
        if (m_fbusy) begin
            m_font[m_fidx] = 0; m_fknown[m_fidx] = 1'b1;
            if (wr) m_dropped = 1'b1;
        end else if (wr) begin
            m_font[font_addr] = font_data; m_fknown[font_addr] = 1'b1;
        end
        if (font_clr) begin
            m_fbusy = 1'b1; m_fidx = 0;
        end else if (m_fbusy) begin
            m_fidx++;
            if (m_fidx == NF) begin m_fbusy = 1'b0; m_fidx = 0; end
        end
        if (m_cidx >= 0) begin
            m_sx[m_cidx] = m_ax[m_cidx]; m_sy[m_cidx] = m_ay[m_cidx]; m_sv[m_cidx] = m_av[m_cidx];
        end
        if (vsync) m_cidx = 0;
        else if (m_cidx >= 0) begin
            m_cidx++;
            if (m_cidx == NS) m_cidx = -1;
        end
        if (sprite_pos) begin m_ax[sprite_sel] = sprite_x; m_ay[sprite_sel] = sprite_y; end
        if (sprite_attr) m_av[sprite_sel] = sprite_vis;
        if (bck_ch_active) m_bck = bck;
    endtask

    task automatic check_all();
        check("rd_x", rd_x, m_rdx);
        check("rd_y", rd_y, m_rdy);
        check("rd_vis", rd_vis, m_rdv);
        check("bck_out", bck_out, m_bck);
        check("font_busy", font_busy, m_fbusy);
        check("copy_busy", copy_busy, (m_cidx >= 0) ? 1 : 0);
        check("font_wr_dropped", font_wr_dropped, m_dropped);
        if (m_rdf_known) check("rd_font_data", rd_font_data, m_rdf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        sprite_pos = 0; sprite_attr = 0; bck_ch_active = 0;
        font_ch_active = 0; font_en = 0; font_clr = 0; vsync = 0;
        check_all();
    endtask

    initial begin
        int n, c32, c16;
        reset = 0;
        sprite_x = 0; sprite_y = 0; sprite_sel = 0; sprite_pos = 0; sprite_attr = 0;
        sprite_vis = 0; bck_ch_active = 0; bck = 0; font_ch_active = 0; font_en = 0;
        font_addr = 0; font_data = 0; font_clr = 0; vsync = 0; rd_spr = 0; rd_font_addr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1;

        // Sprite write with both strobes, then a full shadow copy.
        sprite_sel = 3; sprite_x = 100; sprite_y = 50; sprite_pos = 1;
        sprite_attr = 1; sprite_vis = 1;
        tick();
        vsync = 1;
        tick();
        n = 0;
        while (copy_busy && n < 200) begin n++; tick(); end
        check("copy_busy_cycles", n, 32);
        rd_spr = 3;
        tick();
        check("copy_rd_x", rd_x, 100);
        check("copy_rd_y", rd_y, 50);
        check("copy_rd_vis", rd_vis, 1);

        // Active write without vsync must not reach the shadow table.
        sprite_sel = 3; sprite_x = 7; sprite_pos = 1;
        tick();
        tick();
        check("shadow_isolation", rd_x, 100);

        // Font write, then clear sweep with a dropped write in the middle.
        font_addr = 5; font_data = 4'hA; font_ch_active = 1; font_en = 1;
        tick();
        rd_font_addr = 5;
        tick();
        check("font_wr_rd", rd_font_data, 4'hA);
        font_clr = 1;
        tick();
        n = 0;
        while (font_busy && n < 5000) begin
            n++;
            if (n == 10) begin
                font_addr = 5; font_data = 4'hF; font_ch_active = 1; font_en = 1;
            end
            tick();
        end
        check("font_busy_cycles", n, 2048);
        check("font_dropped", font_wr_dropped, 1);
        tick();
        check("font_cleared", rd_font_data, 0);

        // Restart of the clear sweep and of the copy.
        font_clr = 1;
        tick();
        n = 0;
        while (font_busy && n < 1000) begin n++; tick(); end
        font_clr = 1;
        tick();
        n = 0;
        while (font_busy && n < 5000) begin n++; tick(); end
        check("font_restart_cycles", n, 2048);
        vsync = 1;
        tick();
        repeat (10) tick();
        vsync = 1;
        tick();
        n = 0;
        while (copy_busy && n < 200) begin n++; tick(); end
        check("copy_restart_cycles", n, 32);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            sprite_sel = 5'($urandom_range(31, 0));
            sprite_x = 10'($urandom_range(1023, 0));
            sprite_y = 9'($urandom_range(511, 0));
            sprite_vis = 1'($urandom_range(1, 0));
            sprite_pos = ($urandom_range(3, 0) == 0);
            sprite_attr = ($urandom_range(3, 0) == 0);
            bck = 2'($urandom_range(3, 0));
            bck_ch_active = ($urandom_range(7, 0) == 0);
            font_addr = 11'($urandom_range(15, 0));
            font_data = 4'($urandom_range(15, 0));
            font_ch_active = 1'($urandom_range(1, 0));
            font_en = 1'($urandom_range(1, 0));
            font_clr = ($urandom_range(999, 0) == 0);
            vsync = ($urandom_range(59, 0) == 0);
            rd_spr = 5'($urandom_range(31, 0));
            rd_font_addr = 11'($urandom_range(15, 0));
            tick();
        end
        n = 0;
        while ((font_busy || copy_busy) && n < 5000) begin n++; tick(); end

        // Reset in the middle of a copy clears outputs immediately.
        sprite_sel = 3; sprite_x = 7; sprite_y = 9; sprite_vis = 1;
        sprite_pos = 1; sprite_attr = 1; bck = 3; bck_ch_active = 1;
        font_addr = 2; font_data = 4'hC; font_ch_active = 1; font_en = 1;
        tick();
        vsync = 1;
        tick();
        n = 0;
        while (copy_busy && n < 200) begin n++; tick(); end
        rd_spr = 3; rd_font_addr = 2;
        tick();
        check("pre_rst_rd_x", rd_x, 7);
        check("pre_rst_font", rd_font_data, 4'hC);
        vsync = 1;
        tick();
        repeat (5) tick();
        #2 reset = 0;
        #1;
        check("rst_copy_busy", copy_busy, 0);
        check("rst_rd_x", rd_x, 0);
        check("rst_rd_y", rd_y, 0);
        check("rst_rd_vis", rd_vis, 0);
        check("rst_rd_font", rd_font_data, 0);
        check("rst_bck_out", bck_out, 0);
        check("rst_dropped", font_wr_dropped, 0);
        check("rst_font_busy", font_busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        repeat (4) tick();
        check("no_copy_resume", copy_busy, 0);
        check("rst_shadow_clear", rd_x, 0);

        // Out-of-range read on the 16-entry instance and background update.
        sprite_sel = 31; sprite_x = 555; sprite_pos = 1;
        tick();
        vsync = 1;
        tick();
        n = 0; c32 = 0; c16 = 0;
        while ((copy_busy || copy_busy16) && n < 200) begin
            n++;
            if (copy_busy) c32++;
            if (copy_busy16) c16++;
            tick();
        end
        check("copy16_cycles", c16, 16);
        check("copy32_cycles", c32, 32);
        rd_spr = 31;
        tick();
        check("rd31_x", rd_x, 555);
        check("oor_rd_x16", rd_x16, 0);
        check("oor_rd_y16", rd_y16, 0);
        check("oor_rd_vis16", rd_vis16, 0);
        bck = 2'b10; bck_ch_active = 1;
        tick();
        check("bck_update", bck_out, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
